// File: rtl/retired_rat_gen.sv
// retired_rat_gen: retired register alias table with free-list return and flush rebuild
// Ports:
//   clk, rst             clock; asynchronous active-low reset
//   retire_valid/has_rd  per-way commit qualifiers, way 0 oldest
//   retire_rd_arch/phys  per-way destination and its physical register
//   flush_req            start a free-list rebuild (single-cycle pulse)
//   rebuild_busy         rebuild in progress
//   free_clear           free list empties itself this cycle
//   free_push/free_entry registered pushes of freed physical registers
//   arch_map             table with this cycle's retirements applied
module retired_rat_gen #(
    parameter int SS = 2,
    parameter int PHYS_REGS = 64,
    parameter int ARCH_REGS = 32,
    localparam int PW = $clog2(PHYS_REGS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [SS-1:0]                 retire_valid,
    input  logic [SS-1:0]                 retire_has_rd,
    input  logic [SS-1:0][4:0]            retire_rd_arch,
    input  logic [SS-1:0][PW-1:0]         retire_rd_phys,
    input  logic                          flush_req,
    output logic                          rebuild_busy,
    output logic                          free_clear,
    output logic [SS-1:0]                 free_push,
    output logic [SS-1:0][PW-1:0]         free_entry,
    output logic [ARCH_REGS-1:0][PW-1:0]  arch_map
);
    typedef enum logic [1:0] {IDLE, CLEAR, SCAN} state_t;
    state_t state, nxt_state;
    logic [ARCH_REGS-1:0][PW-1:0] map, nxt_map;
    logic [SS-1:0] eff, scan_push;
    logic [SS-1:0][PW-1:0] freed;
    logic [SS-1:0][PW:0] scan_idx;
    logic [PHYS_REGS-1:0] mapped;
    logic [PW:0] ptr;
    logic last, scan_tail;
    // Ways are visited oldest first so younger writes and forwards overwrite older ones.
    always_comb begin
        eff = '0;
        freed = '0;
        nxt_map = map;
        for (int i = 0; i < SS; i++) begin
            eff[i] = state == IDLE && retire_valid[i] && retire_has_rd[i] && retire_rd_arch[i] != '0;
            freed[i] = map[retire_rd_arch[i]];
            for (int j = 0; j < i; j++)
                if (eff[j] && retire_rd_arch[j] == retire_rd_arch[i]) freed[i] = retire_rd_phys[j];
            if (eff[i]) nxt_map[retire_rd_arch[i]] = retire_rd_phys[i];
        end
    end
    assign arch_map = nxt_map;
    // Scan compares candidates against the registered table; p0 is never free.
    always_comb begin
        mapped = '0;
        for (int r = 0; r < ARCH_REGS; r++) mapped[map[r]] = 1'b1;
        mapped[0] = 1'b1;
        for (int k = 0; k < SS; k++) begin
            scan_idx[k] = ptr + (PW+1)'(k);
            scan_push[k] = scan_idx[k] < (PW+1)'(PHYS_REGS) && !mapped[scan_idx[k][PW-1:0]];
        end
    end
    assign last = int'(ptr) + SS >= PHYS_REGS;
    assign nxt_state = (state == IDLE && flush_req && !scan_tail) ? CLEAR :
                       (state == CLEAR) ? SCAN :
                       (state == SCAN && last) ? IDLE : state;
    // scan_tail covers the cycle that carries the final group's pushes.
    assign rebuild_busy = state != IDLE || scan_tail;
    assign free_clear = state == CLEAR;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            ptr <= '0;
            scan_tail <= 1'b0;
            free_push <= '0;
            free_entry <= '0;
            for (int r = 0; r < ARCH_REGS; r++) map[r] <= PW'(r);
        end else begin
            state <= nxt_state;
            map <= nxt_map;
            ptr <= (state == SCAN && !last) ? ptr + (PW+1)'(SS) : '0;
            scan_tail <= state == SCAN && last;
            for (int k = 0; k < SS; k++) begin
                free_push[k] <= state == SCAN ? scan_push[k] : eff[k];
                free_entry[k] <= state == SCAN ? (scan_push[k] ? scan_idx[k][PW-1:0] : '0) :
                                 (eff[k] ? freed[k] : '0);
            end
        end
    end
endmodule

// File: tb/tb_retired_rat_gen.sv
// tb_retired_rat_gen: directed scoreboard bench for retired_rat_gen (SS=2, 64 phys, 32 arch)
module tb_retired_rat_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [1:0] retire_valid = '0;
    logic [1:0] retire_has_rd = '0;
    logic [1:0][4:0] retire_rd_arch = '0;
    logic [1:0][5:0] retire_rd_phys = '0;
    logic flush_req = 1'b0;
    logic rebuild_busy, free_clear;
    logic [1:0] free_push;
    logic [1:0][5:0] free_entry;
    logic [31:0][5:0] arch_map;

    int total = 0;
    int bad = 0;
    int busy_cnt = 0;
    int clr_cnt = 0;
    int ref_map [32];
    logic [5:0] exp_q [$];

    retired_rat_gen #(.SS(2), .PHYS_REGS(64), .ARCH_REGS(32)) dut (
        .clk(clk), .rst(rst),
        .retire_valid(retire_valid), .retire_has_rd(retire_has_rd),
        .retire_rd_arch(retire_rd_arch), .retire_rd_phys(retire_rd_phys),
        .flush_req(flush_req), .rebuild_busy(rebuild_busy), .free_clear(free_clear),
        .free_push(free_push), .free_entry(free_entry), .arch_map(arch_map)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s got=%0d want=%0d", tag, got, want);
        end
    endtask

    task automatic check_map(input string tag);
        for (int r = 0; r < 32; r++) chk($sformatf("%s_map%0d", tag, r), int'(arch_map[r]), ref_map[r]);
    endtask

    // Advance one cycle and pop the scoreboard for every push the DUT emits.
    task automatic tick();
        logic [5:0] e;
        @(posedge clk);
        #1;
        if (rebuild_busy) busy_cnt++;
        if (free_clear) clr_cnt++;
        for (int k = 0; k < 2; k++) if (free_push[k]) begin
            total++;
            assert (exp_q.size() != 0) else begin
                bad++;
                $error("FAIL push_extra lane=%0d got=%0d want=none", k, free_entry[k]);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                assert (free_entry[k] === e) else begin
                    bad++;
                    $error("FAIL push_entry lane=%0d got=%0d want=%0d", k, free_entry[k], e);
                end
            end
        end
    endtask

    task automatic push_scan();
        logic [63:0] m;
        m = '0;
        m[0] = 1'b1;
        for (int r = 0; r < 32; r++) m[ref_map[r]] = 1'b1;
        for (int p = 0; p < 64; p++) if (!m[p]) exp_q.push_back(6'(p));
    endtask

    task automatic drive(input logic v0, input logic h0, input int a0, input int p0,
                         input logic v1, input logic h1, input int a1, input int p1,
                         input logic fl);
        logic e0, e1;
        retire_valid = {v1, v0};
        retire_has_rd = {h1, h0};
        retire_rd_arch[0] = 5'(a0);
        retire_rd_arch[1] = 5'(a1);
        retire_rd_phys[0] = 6'(p0);
        retire_rd_phys[1] = 6'(p1);
        flush_req = fl;
        e0 = v0 && h0 && a0 != 0;
        e1 = v1 && h1 && a1 != 0;
        if (e0) exp_q.push_back(6'(ref_map[a0]));
        if (e1) exp_q.push_back((e0 && a0 == a1) ? 6'(p0) : 6'(ref_map[a1]));
        if (e0) ref_map[a0] = p0;
        if (e1) ref_map[a1] = p1;
        if (fl) push_scan();
        #1;
        check_map("comb");
        tick();
        retire_valid = '0;
        retire_has_rd = '0;
        flush_req = 1'b0;
    endtask

    task automatic apply_reset();
        exp_q.delete();
        for (int r = 0; r < 32; r++) ref_map[r] = r;
        rst = 1'b0;
        #1;
        chk("rst_busy", int'(rebuild_busy), 0);
        chk("rst_clear", int'(free_clear), 0);
        chk("rst_push", int'(free_push), 0);
        chk("rst_entry", int'(free_entry), 0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        check_map("rst");
        chk("rst_idle_push", int'(free_push), 0);
        chk("rst_idle_busy", int'(rebuild_busy), 0);
    endtask

    initial begin
        #1;
        apply_reset();
        drive(1, 1, 5, 40, 0, 0, 0, 0, 0);
        chk("single_q", exp_q.size(), 0);
        drive(1, 1, 5, 41, 1, 1, 6, 42, 0);
        chk("dual_q", exp_q.size(), 0);
        drive(1, 1, 7, 33, 1, 1, 7, 34, 0);
        chk("collide_q", exp_q.size(), 0);
        #1;
        check_map("collide");
        drive(1, 1, 0, 12, 1, 0, 9, 13, 0);
        tick();
        check_map("filter");
        chk("filter_q", exp_q.size(), 0);
        apply_reset();
        busy_cnt = 0;
        clr_cnt = 0;
        drive(1, 1, 3, 50, 0, 0, 0, 0, 1);
        repeat (3) tick();
        retire_valid = 2'b01;
        retire_has_rd = 2'b01;
        retire_rd_arch[0] = 5'd9;
        retire_rd_phys[0] = 6'd60;
        flush_req = 1'b1;
        #1;
        check_map("ignored");
        tick();
        retire_valid = '0;
        retire_has_rd = '0;
        flush_req = 1'b0;
        repeat (36) tick();
        chk("flush_busy_cycles", busy_cnt, 34);
        chk("flush_clear_cycles", clr_cnt, 1);
        chk("flush_q", exp_q.size(), 0);
        chk("flush_busy_end", int'(rebuild_busy), 0);
        check_map("flush_end");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        repeat (5) tick();
        chk("midscan_busy", int'(rebuild_busy), 1);
        apply_reset();
        repeat (3) tick();
        busy_cnt = 0;
        clr_cnt = 0;
        drive(1, 1, 1, 40, 0, 0, 0, 0, 1);
        repeat (40) tick();
        chk("restart_busy_cycles", busy_cnt, 34);
        chk("restart_clear_cycles", clr_cnt, 1);
        chk("restart_q", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
